// File: rtl/mimo_pkg.sv
// ============================================================================
// Module      : mimo_pkg
// Description : Shared widths, word type and sender FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mimo_pkg;

    localparam int c_INT_W   = 2;
    localparam int c_FRAC_W  = 15;
    localparam int c_I_WIDTH = c_INT_W + c_FRAC_W;
    localparam int c_WORD_W  = c_I_WIDTH * 8;
    localparam int c_R_ROWS  = 4;

    // Four complex components, re/im interleaved exactly as the detector's InData
    typedef logic [c_WORD_W-1:0] cvec_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_R    = 2'd1,
        ST_SEND_Y    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mimo_frame_sender_if.sv
// ============================================================================
// Module      : mimo_frame_sender_if
// Description : Upstream word stream plus detector input/result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mimo_frame_sender_if
    import mimo_pkg::*;
#(
    parameter int I_WIDTH = c_I_WIDTH
);

    logic                 s_valid;
    logic                 s_is_channel;
    logic [I_WIDTH*8-1:0] s_data;
    logic                 s_ready;

    logic [I_WIDTH*8-1:0] InData;
    logic                 flagChannelorData;
    logic                 i_in_valid;
    logic                 o_in_ready;
    logic                 OutputReady;

    modport master (
        input  s_valid, s_is_channel, s_data, o_in_ready, OutputReady,
        output s_ready, InData, flagChannelorData, i_in_valid
    );

    modport slave (
        output s_valid, s_is_channel, s_data, o_in_ready, OutputReady,
        input  s_ready, InData, flagChannelorData, i_in_valid
    );

endinterface

`default_nettype wire

// File: rtl/mimo_y_fifo.sv
// ============================================================================
// Module      : mimo_y_fifo
// Description : Synchronous FIFO for queued Y vectors, active-low sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mimo_y_fifo
    import mimo_pkg::*;
#(
    parameter int WIDTH = c_WORD_W,
    parameter int DEPTH = 4
) (
    input  wire              Clk,
    input  wire              Reset,
    input  wire              push,
    input  wire [WIDTH-1:0]  push_data,
    input  wire              pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_count == (c_AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mimo_frame_sender.sv
// ============================================================================
// Module      : mimo_frame_sender
// Description : Caches one 4-row R matrix and replays R + each queued Y to the
//               MIMO detector. Optional watchdog: MIMO_SENDER_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mimo_frame_sender
    import mimo_pkg::*;
#(
    parameter int INT_W   = c_INT_W,
    parameter int FRAC_W  = c_FRAC_W,
    parameter int I_WIDTH = INT_W + FRAC_W,
    parameter int Y_DEPTH = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire                  Clk,
    input  wire                  Reset,
    mimo_frame_sender_if.master  bus,
    output logic                 busy,
    output logic [15:0]          frames_done,
    output logic                 err_timeout
);

    localparam int c_W = I_WIDTH * 8;

    if (Y_DEPTH < 2 || (Y_DEPTH & (Y_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("mimo_frame_sender: Y_DEPTH must be a power of 2 >= 2, TIMEOUT >= 2");
    end

    state_t         r_state;
    logic [c_W-1:0] r_mem [c_R_ROWS];
    logic [1:0]     r_idx;
    logic [1:0]     r_tx_idx;
    logic           r_loaded;
    logic [c_W-1:0] r_in_data;
    logic           r_flag;
    logic [15:0]    r_frames_done;

    logic           w_s_ready;
    logic           w_ch_wr;
    logic           w_y_push;
    logic           w_xfer;
    logic           w_pop;
    logic           w_done;
    logic           w_timeout;
    logic [1:0]     w_next_tx;
    logic [c_W-1:0] w_fifo_head;
    logic           w_fifo_full;
    logic           w_fifo_empty;

    // Channel words may only rewrite R while nothing is queued or in flight
    assign w_s_ready = bus.s_is_channel ? (r_state == ST_IDLE && w_fifo_empty)
                                        : (r_loaded && !w_fifo_full);
    assign w_ch_wr   = bus.s_valid && w_s_ready && bus.s_is_channel;
    assign w_y_push  = bus.s_valid && w_s_ready && !bus.s_is_channel;

    assign w_xfer    = (r_state == ST_SEND_R || r_state == ST_SEND_Y) && bus.o_in_ready;
    assign w_pop     = (r_state == ST_SEND_Y) && w_xfer;
    assign w_done    = (r_state == ST_WAIT_DONE) && bus.OutputReady;
    assign w_next_tx = r_tx_idx + 2'd1;

    assign bus.s_ready           = w_s_ready;
    assign bus.i_in_valid        = w_xfer;
    assign bus.InData            = r_in_data;
    assign bus.flagChannelorData = r_flag;
    assign busy                  = (r_state != ST_IDLE);
    assign frames_done           = r_frames_done;

    mimo_y_fifo #(
        .WIDTH (c_W),
        .DEPTH (Y_DEPTH)
    ) u_y_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (w_y_push),
        .push_data (bus.s_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge Clk) begin
        if (w_ch_wr) begin
            r_mem[r_idx] <= bus.s_data;
        end
    end

    // A write to row 0 after a complete matrix starts a fresh one
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_idx    <= 2'd0;
            r_loaded <= 1'b0;
        end else if (w_ch_wr) begin
            r_idx    <= r_idx + 2'd1;
            r_loaded <= (r_idx == 2'd3);
        end
    end

`ifdef MIMO_SENDER_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_err_timeout;

    assign w_timeout   = (r_state == ST_WAIT_DONE) && !bus.OutputReady
                         && (r_wd_cnt == c_WD_W'(TIMEOUT - 1));
    assign err_timeout = r_err_timeout;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state != ST_WAIT_DONE || w_timeout) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // InData/flag are registered one step ahead so they are valid on state entry
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_tx_idx      <= 2'd0;
            r_in_data     <= '0;
            r_flag        <= 1'b0;
            r_frames_done <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_loaded && !w_fifo_empty) begin
                        r_state   <= ST_SEND_R;
                        r_tx_idx  <= 2'd0;
                        r_in_data <= r_mem[0];
                        r_flag    <= 1'b1;
                    end
                end
                ST_SEND_R: begin
                    if (w_xfer) begin
                        if (r_tx_idx == 2'd3) begin
                            r_state   <= ST_SEND_Y;
                            r_tx_idx  <= 2'd0;
                            r_in_data <= w_fifo_head;
                            r_flag    <= 1'b0;
                        end else begin
                            r_tx_idx  <= w_next_tx;
                            r_in_data <= r_mem[w_next_tx];
                        end
                    end
                end
                ST_SEND_Y: begin
                    if (w_xfer) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_done || w_timeout) begin
                        if (w_done) begin
                            r_frames_done <= r_frames_done + 16'd1;
                        end
                        if (!w_fifo_empty) begin
                            r_state   <= ST_SEND_R;
                            r_tx_idx  <= 2'd0;
                            r_in_data <= r_mem[0];
                            r_flag    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_flag  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mimo_frame_sender.sv
// ============================================================================
// Module      : tb_mimo_frame_sender
// Description : Scoreboard bench for mimo_frame_sender (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mimo_frame_sender;
    import mimo_pkg::*;

    localparam int c_W = c_WORD_W;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        busy;
    logic [15:0] frames_done;
    logic        err_timeout;

    always #5 Clk = ~Clk;

    mimo_frame_sender_if #(.I_WIDTH(c_I_WIDTH)) bus ();

    mimo_frame_sender #(
        .INT_W   (c_INT_W),
        .FRAC_W  (c_FRAC_W),
        .I_WIDTH (c_I_WIDTH),
        .Y_DEPTH (4),
        .TIMEOUT (16)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .bus         (bus),
        .busy        (busy),
        .frames_done (frames_done),
        .err_timeout (err_timeout)
    );

    logic [c_W:0] expq [$];
    cvec_t        r_cur [4];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_xfer   = 0;
    int           n_yx     = 0;

    function automatic cvec_t wd(input logic [7:0] b);
        return {c_I_WIDTH{b}};
    endfunction

    task automatic check(input string name, input logic [c_W:0] act, input logic [c_W:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every detector transfer must match the next expected word
    always @(negedge Clk) begin
        if (bus.i_in_valid) begin
            n_xfer++;
            if (!bus.flagChannelorData) n_yx++;
            check("valid_needs_ready", (c_W+1)'(bus.o_in_ready), (c_W+1)'(1));
            if (expq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_xfer: got %0h expected none",
                         {bus.flagChannelorData, bus.InData});
            end else begin
                check("xfer_word", {bus.flagChannelorData, bus.InData}, expq.pop_front());
            end
        end
    end

    task automatic push(input logic ch, input cvec_t d);
        bit ok = 0;
        bus.s_valid      = 1'b1;
        bus.s_is_channel = ch;
        bus.s_data       = d;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge Clk);
            if (bus.s_ready) ok = 1;
            @(posedge Clk);
            #1;
        end
        bus.s_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL push_timeout: got s_ready=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic load_r(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            push(1'b1, wd(b + 8'(i)));
            r_cur[i] = wd(b + 8'(i));
        end
    endtask

    task automatic expect_frame(input cvec_t y);
        for (int i = 0; i < 4; i++) expq.push_back({1'b1, r_cur[i]});
        expq.push_back({1'b0, y});
    endtask

    task automatic wait_y();
        int s;
        s = n_yx;
        for (int k = 0; k < 200 && n_yx == s; k++) @(posedge Clk);
        if (n_yx == s) begin
            n_checks++;
            $display("FAIL y_xfer_timeout: got no Y transfer expected one within 200 cycles");
        end
        #1;
    endtask

    task automatic pulse_or();
        bus.OutputReady = 1'b1;
        @(posedge Clk);
        #1;
        bus.OutputReady = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        bus.s_valid      = 1'b0;
        bus.s_is_channel = 1'b0;
        bus.s_data       = '0;
        bus.o_in_ready   = 1'b1;
        bus.OutputReady  = 1'b0;

        // Reset values
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy",   (c_W+1)'(busy), '0);
        check("rst_frames", (c_W+1)'(frames_done), '0);
        check("rst_valid",  (c_W+1)'(bus.i_in_valid), '0);
        check("rst_data",   {bus.flagChannelorData, bus.InData}, '0);
        check("rst_err",    (c_W+1)'(err_timeout), '0);
        check("rst_sready_y", (c_W+1)'(bus.s_ready), '0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        bus.s_is_channel = 1'b1;
        @(negedge Clk);
        check("idle_sready_ch", (c_W+1)'(bus.s_ready), (c_W+1)'(1));
        @(posedge Clk); #1;

        // Single frame with ready held high: five back-to-back transfers
        load_r(8'h01);
        expect_frame(wd(8'hAA));
        push(1'b0, wd(8'hAA));
        @(posedge Clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("burst_valid", (c_W+1)'(bus.i_in_valid), (c_W+1)'(1));
        end
        @(negedge Clk);
        check("wait_valid", (c_W+1)'(bus.i_in_valid), '0);
        check("wait_busy",  (c_W+1)'(busy), (c_W+1)'(1));
        @(posedge Clk); #1;
        pulse_or();
        @(negedge Clk);
        check("f1_frames", (c_W+1)'(frames_done), (c_W+1)'(1));
        check("f1_busy",   (c_W+1)'(busy), '0);
        @(posedge Clk); #1;

        // Three queued Y vectors, each replays the same R
        for (int i = 0; i < 3; i++) begin
            expect_frame(wd(8'hBB + 8'(i)));
            push(1'b0, wd(8'hBB + 8'(i)));
        end
        for (int i = 0; i < 3; i++) begin
            wait_y();
            repeat (9) @(posedge Clk);
            #1;
            pulse_or();
        end
        @(negedge Clk);
        check("f3_frames", (c_W+1)'(frames_done), (c_W+1)'(4));
        check("f3_busy",   (c_W+1)'(busy), '0);
        @(posedge Clk); #1;

        // OutputReady outside WAIT_DONE is ignored
        pulse_or();
        @(negedge Clk);
        check("or_ignored", (c_W+1)'(frames_done), (c_W+1)'(4));
        @(posedge Clk); #1;

        // Toggling ready: transfers only on ready cycles, order preserved
        s = n_xfer;
        expect_frame(wd(8'hEE));
        push(1'b0, wd(8'hEE));
        begin
            int y0;
            y0 = n_yx;
            for (int k = 0; k < 60 && n_yx == y0; k++) begin
                @(posedge Clk); #1;
                bus.o_in_ready = ~bus.o_in_ready;
            end
        end
        bus.o_in_ready = 1'b1;
        check("toggle_xfers", (c_W+1)'(n_xfer - s), (c_W+1)'(5));
        pulse_or();
        @(negedge Clk);
        check("toggle_frames", (c_W+1)'(frames_done), (c_W+1)'(5));
        @(posedge Clk); #1;

        // Detector stalled: fill the queue, then back-pressure
        bus.o_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_frame(wd(8'hF0 + 8'(i)));
            push(1'b0, wd(8'hF0 + 8'(i)));
        end
        bus.s_valid = 1'b1; bus.s_is_channel = 1'b0; bus.s_data = wd(8'hFF);
        @(negedge Clk);
        check("full_sready_y", (c_W+1)'(bus.s_ready), '0);
        @(posedge Clk); #1;
        bus.s_is_channel = 1'b1;
        @(negedge Clk);
        check("busy_sready_ch", (c_W+1)'(bus.s_ready), '0);
        @(posedge Clk); #1;
        bus.s_valid = 1'b0;
        bus.o_in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_y();
            repeat (2) @(posedge Clk);
            #1;
            pulse_or();
        end
        @(negedge Clk);
        check("stall_frames", (c_W+1)'(frames_done), (c_W+1)'(9));
        check("stall_busy",   (c_W+1)'(busy), '0);
        @(posedge Clk); #1;

        // Reset while row 2 is being presented
        expq.push_back({1'b1, r_cur[0]});
        expq.push_back({1'b1, r_cur[1]});
        push(1'b0, wd(8'h77));
        repeat (3) @(posedge Clk);
        #1;
        bus.o_in_ready = 1'b0;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        bus.o_in_ready = 1'b1;
        bus.s_valid = 1'b1; bus.s_is_channel = 1'b0; bus.s_data = wd(8'h66);
        @(negedge Clk);
        check("mid_rst_valid",  (c_W+1)'(bus.i_in_valid), '0);
        check("mid_rst_busy",   (c_W+1)'(busy), '0);
        check("mid_rst_frames", (c_W+1)'(frames_done), '0);
        check("mid_rst_data",   {bus.flagChannelorData, bus.InData}, '0);
        check("mid_rst_sready", (c_W+1)'(bus.s_ready), '0);
        check("mid_rst_q",      (c_W+1)'(expq.size()), '0);
        @(posedge Clk); #1;
        bus.s_valid = 1'b0;

        // Fresh matrix, then a fifth channel word restarts it
        load_r(8'h05);
        push(1'b1, wd(8'h11));
        bus.s_is_channel = 1'b0;
        @(negedge Clk);
        check("new_matrix_sready", (c_W+1)'(bus.s_ready), '0);
        @(posedge Clk); #1;
        r_cur[0] = wd(8'h11);
        for (int i = 1; i < 4; i++) begin
            push(1'b1, wd(8'h11 + 8'(i)));
            r_cur[i] = wd(8'h11 + 8'(i));
        end
        expect_frame(wd(8'h99));
        push(1'b0, wd(8'h99));
        wait_y();
        repeat (2) @(posedge Clk);
        #1;
        pulse_or();
        @(negedge Clk);
        check("post_rst_frames", (c_W+1)'(frames_done), (c_W+1)'(1));
        check("post_rst_busy",   (c_W+1)'(busy), '0);
        @(posedge Clk); #1;

`ifdef MIMO_SENDER_WATCHDOG_EN
        expect_frame(wd(8'h5A));
        push(1'b0, wd(8'h5A));
        wait_y();
        repeat (15) @(posedge Clk);
        #1;
        check("wd_err_early", (c_W+1)'(err_timeout), '0);
        check("wd_busy_early", (c_W+1)'(busy), (c_W+1)'(1));
        @(posedge Clk); #1;
        check("wd_err",    (c_W+1)'(err_timeout), (c_W+1)'(1));
        check("wd_busy",   (c_W+1)'(busy), '0);
        check("wd_frames", (c_W+1)'(frames_done), (c_W+1)'(1));
`else
        check("err_tied", (c_W+1)'(err_timeout), '0);
`endif

        for (int k = 0; k < 100 && expq.size() != 0; k++) @(posedge Clk);
        check("scoreboard_drained", (c_W+1)'(expq.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
